// File: rtl/if_id_stage_if.sv
// Fetch-side bus of the IF/ID stage: instruction memory port,
// hazard controls from ID, and the IF/ID register outputs.
interface if_id_stage_if;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] id_instr;
  logic [15:0] id_imm16;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        id_fetch_exc;

  modport master (
    output im_addr,
    input  im_rdata,
    input  stall,
    input  flush,
    input  redirect_en,
    input  redirect_pc,
    output id_instr,
    output id_imm16,
    output id_pc,
    output id_pc8,
    output id_valid,
    output id_fetch_exc
  );

  modport slave (
    input  im_addr,
    output im_rdata,
    output stall,
    output flush,
    output redirect_en,
    output redirect_pc,
    input  id_instr,
    input  id_imm16,
    input  id_pc,
    input  id_pc8,
    input  id_valid,
    input  id_fetch_exc
  );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID pipeline register: PC, stall,
// flush, delay-slot redirect and fetch-window checking.
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input logic          clk,
  input logic          reset,
  if_id_stage_if.master bus
);

  localparam logic [32:0] LP_BASE = {1'b0, PC_RESET};
  localparam logic [32:0] LP_END  =
    LP_BASE + (33'(IM_WORDS) << 2);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_valid;
  logic        r_id_exc;
  logic        w_bad;

  // Fetch address is legal only if aligned and inside the IM window
  always_comb begin
    w_bad = 1'b0;
    if (r_pc[1:0] != 2'b00)
      w_bad = 1'b1;
    if ({1'b0, r_pc} < LP_BASE)
      w_bad = 1'b1;
    if ({1'b0, r_pc} >= LP_END)
      w_bad = 1'b1;
  end

  // PC and IF/ID update; stall freezes everything, redirect never kills the slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= PC_RESET;
      r_id_instr <= 32'd0;
      r_id_pc    <= 32'd0;
      r_id_valid <= 1'b0;
      r_id_exc   <= 1'b0;
    end else if (!bus.stall) begin
      r_pc    <= bus.redirect_en ? bus.redirect_pc
                                 : r_pc + 32'd4;
      r_id_pc <= r_pc;
      if (bus.flush) begin
        r_id_instr <= 32'd0;
        r_id_valid <= 1'b0;
        r_id_exc   <= 1'b0;
      end else if (w_bad) begin
        r_id_instr <= 32'd0;
        r_id_valid <= 1'b1;
        r_id_exc   <= 1'b1;
      end else begin
        r_id_instr <= bus.im_rdata;
        r_id_valid <= 1'b1;
        r_id_exc   <= 1'b0;
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    bus.im_addr      = r_pc;
    bus.id_instr     = r_id_instr;
    bus.id_imm16     = r_id_instr[15:0];
    bus.id_pc        = r_id_pc;
    bus.id_pc8       = r_id_pc + 32'd8;
    bus.id_valid     = r_id_valid;
    bus.id_fetch_exc = r_id_exc;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word and its PC into IF/ID.
- Presents the imm16 field to the immediate-extension unit and the decoder in ID.
- Implements stall, flush, branch/jump redirect (delay-slot semantics) and fetch-address checking.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset; also base of the legal fetch window.
IM_WORDS, 4096, number of 32-bit words in instruction memory; legal window is [PC_RESET, PC_RESET + 4*IM_WORDS).

Ports:
clk  in  1  clock, rising-edge active.
reset  in  1  asynchronous, active-high reset.
im_addr  out  32  fetch address to instruction memory, equal to the current PC register (combinational).
im_rdata  in  32  instruction word at im_addr, combinational read, valid in the same cycle.
stall  in  1  hazard stall from ID; freezes PC and IF/ID.
flush  in  1  kill the word being fetched this cycle (IF/ID loads a bubble).
redirect_en  in  1  branch taken or jump resolved in ID this cycle.
redirect_pc  in  32  target address for redirect_en.
id_instr  out  32  IF/ID instruction; id_instr[15:0] is the imm16 source for extension.
id_imm16  out  16  equal to id_instr[15:0].
id_pc  out  32  PC of id_instr.
id_pc8  out  32  id_pc + 8 (link address), modulo 2^32, combinational from the register.
id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
id_fetch_exc  out  1  IF/ID word came from an illegal fetch address.

Behaviour:
- Reset (async, asserted): PC = PC_RESET; id_instr = 0; id_pc = 0; id_valid = 0; id_fetch_exc = 0. This gives id_pc8 = 8 and id_imm16 = 0.
- Reset deassertion: the first rising edge after it latches the word at PC_RESET.
- Legal-fetch check, on the current PC:
  - bad = (PC[1:0] != 0), or PC < PC_RESET, or PC >= PC_RESET + 4*IM_WORDS.
  - The comparison is unsigned and 33-bit, so the window end must not overflow.
- Per rising edge, priority stall > flush/redirect:
  - stall = 1:
    - PC holds. All IF/ID registers hold.
    - redirect_en and flush are ignored. ID re-presents the branch after the stall clears.
  - stall = 0, PC update:
    - next PC = redirect_pc if redirect_en, else PC + 4 (mod 2^32).
  - stall = 0, IF/ID update, flush = 1:
    - id_instr = 0 (NOP), id_valid = 0, id_fetch_exc = 0.
    - id_pc = PC. The PC still advances per the redirect rule.
  - stall = 0, IF/ID update, flush = 0, bad = 1:
    - id_instr = 0, id_valid = 1, id_fetch_exc = 1, id_pc = PC.
  - stall = 0, IF/ID update, otherwise:
    - id_instr = im_rdata, id_valid = 1, id_fetch_exc = 0, id_pc = PC.
- Delay slot: redirect does not flush. The instruction fetched in the redirect cycle (branch PC + 4) enters IF/ID normally. The target is fetched the following cycle.
- redirect_pc misaligned or out of window: accepted into PC unchanged. The fault appears as id_fetch_exc on the next latch.
- PC wrap: 32'hFFFF_FFFC + 4 = 0. The fetch at 0 is flagged bad for default parameters.
- Latency: im_rdata sampled at the edge appears on id_* one cycle after it was addressed. No internal combinational path from stall, flush or redirect_* to any output.
- Reset mid-stall or mid-redirect: reset wins immediately. All pending redirects are discarded.

Test Plan:
- Reset then free-run, IM word i = 32'h2400_0000 + i. Required: id_pc = 0x3000, 0x3004, 0x3008 on successive cycles; id_instr = 0x24000000, 0x24000001, …; id_imm16 = 0x0000, 0x0001, …; id_pc8 = id_pc + 8; id_valid = 1.
- Stall held 3 cycles with a word at 0x3008 in IF/ID, redirect_en = 1 during the stall. Required: id_pc stays 0x3008 and im_addr stays 0x300C for 3 cycles; the redirect is ignored; stall release resumes at 0x300C.
- Branch in ID at 0x3010, redirect_en = 1, redirect_pc = 0x3100 for one cycle. Required: next id_pc = 0x3014 (delay slot, valid = 1); then id_pc = 0x3100.
- flush = 1 while fetching 0x3020. Required: IF/ID gets id_instr = 0, id_valid = 0, id_pc = 0x3020; next id_pc = 0x3024.
- redirect_pc = 0x3002, then separately 0x0000_2FFC. Required: each latches id_fetch_exc = 1, id_instr = 0, id_valid = 1.
- Async reset pulse mid-cycle while redirect_en = 1. Required: outputs clear immediately without a clock edge; PC = 0x3000 afterwards.
